sgm_path_sequencer: RTL and testbench
=====================================

// Module: sgm_path_sequencer
// PURPOSE
//  Sequences one SGM path-cost pipeline (path cost calculator + RAM delay line) over a raster frame.
//  Tracks column/row of the accepted cost vector and drives the pipeline/delay-line clock enable.
//  Flags path-start borders, where the previous path costs must read as zero.
//  Double-buffers P1/P2 so penalties change only between frames; drains pipeline and signals frame end.
// PARAMETERS
//  IMG_WIDTH     640  pixels per row (>=2)
//  IMG_HEIGHT    480  rows per frame (>=2)
//  PATH_DIR      0    0=horizontal (border col 0), 1=vertical (border row 0), 2=diagonal (col 0 or row 0)
//  PIPE_LATENCY  1    cycles from accepted C vector to valid L vector (>=1)
//  PEN_BITS      8    width of P1/P2
//  DEFAULT_P1    4    P1 after reset
//  DEFAULT_P2    32   P2 after reset
// PORTS
//  in_clk        in   1         clock
//  in_rst        in   1         synchronous active-high reset
//  in_valid      in   1         upstream C vector valid
//  out_ready     out  1         sequencer accepts C vector; accept = in_valid & out_ready
//  in_cfg_wr     in   1         write pending penalties
//  in_cfg_P1     in   PEN_BITS  pending P1
//  in_cfg_P2     in   PEN_BITS  pending P2
//  out_P1        out  PEN_BITS  active P1 to calculator
//  out_P2        out  PEN_BITS  active P2 to calculator
//  out_ce        out  1         calculator/delay-line enable (= accept, combinational)
//  out_border    out  1         accepted vector is path start: force prev path costs to 0
//  out_col       out  clog2(IMG_WIDTH)   column of current vector
//  out_row       out  clog2(IMG_HEIGHT)  row of current vector
//  out_L_valid   out  1         out_L_arr valid, accept delayed by PIPE_LATENCY
//  out_frame_done out 1         one-cycle pulse, last L of frame drained
//  out_err       out  1         sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE, col=row=0, out_ready=1, out_L_valid=0, out_frame_done=0, out_err=0.
//   out_P1/out_P2 = DEFAULT_P1/DEFAULT_P2; pending-valid flag cleared; latency shift register cleared.
//  FSM IDLE -> RUN on first accept; RUN -> FLUSH on accept at (IMG_WIDTH-1, IMG_HEIGHT-1).
//   FLUSH -> IDLE after PIPE_LATENCY cycles; out_frame_done pulses on the FLUSH exit cycle,
//   coincident with the final out_L_valid.
//  out_ready = 1 in IDLE and RUN; 0 in FLUSH. Bubbles (in_valid=0) freeze counters and out_ce=0.
//  Counters: col++ per accept; col wraps to 0 and row++ at IMG_WIDTH-1; both wrap to 0 at frame end.
//  out_border is combinational from the current counters and PATH_DIR; meaningful only while out_ce=1.
//  out_L_valid: PIPE_LATENCY-deep shift of accept; it keeps shifting in FLUSH.
//  Config: in_cfg_wr loads the pending regs and sets pending-valid; a later write overwrites.
//   Pending is copied to out_P1/out_P2 on any IDLE cycle with no accept.
//   cfg_wr on the same cycle as the first accept: the frame uses old values; new values apply next frame.
//   out_P1/out_P2 never change in RUN or FLUSH.
//  Reset mid-frame: immediate return to reset state; in-flight L discarded; no frame_done.
//  Arithmetic: counters unsigned, compare with == against IMG_*-1; no saturation needed.
// CONFIGURATION
//  SGM_SEQ_ERR_CHECK_EN defined: out_err sets when in_valid=1 while out_ready=0 (FLUSH).
//   Once set, out_err stays 1 until in_rst. Offending data ignored; FSM unaffected.
//  Not defined: out_err tied 0; no checker logic.
// STRUCTURE
//  Shared include sgm_params.vh: DISPARITY_LEVELS, COST_BITS, ACC_COST_BITS,
//   PATH_DIR_* codes, FSM state encodings (IDLE/RUN/FLUSH).
//  clog2 comes from util/clog2_fun.v.
//  One sub-module, sgm_scan_counter: col/row counters with enable, wrap and last-pixel flag.
// TESTING (IMG_WIDTH=8, IMG_HEIGHT=4, PIPE_LATENCY=1 unless noted)
//  Reset, 32 back-to-back valids -> col/row sweep 0..7 x 0..3; out_L_valid 32 cycles, 1 cycle late;
//   frame_done 1 cycle after accept 32; out_ready=0 for 1 cycle.
//  PATH_DIR=0/1/2, full frame -> out_border on 4 / 8 / 11 accepts, at the col0 / row0 / either positions.
//  Valid gaps every 3rd cycle -> counters and out_ce hold across bubbles; 32 L_valids total, order preserved.
//  cfg_wr P1=10,P2=50 mid-RUN -> out_P1/out_P2 stay 4/32 until IDLE; next frame sees 10/50.
//   cfg_wr on the first-accept cycle -> change deferred one frame.
//  in_rst at col=3,row=2 -> next cycle col=row=0, IDLE, no frame_done; next frame completes normally.
//  PIPE_LATENCY=3, in_valid held high through FLUSH with SGM_SEQ_ERR_CHECK_EN -> out_ready=0 for 3 cycles;
//   out_err=1 sticky; frame_done still pulses once.

Source files
------------

// File: rtl/sgm_path_sequencer_pkg.sv
// Shared constants, state encoding and path-start helper for the SGM path sequencer.
package sgm_path_sequencer_pkg;

    localparam int unsigned DISPARITY_LEVELS = 64;
    localparam int unsigned COST_BITS        = 6;
    localparam int unsigned ACC_COST_BITS    = 11;

    localparam int unsigned PATH_DIR_HORIZ   = 0;
    localparam int unsigned PATH_DIR_VERT    = 1;
    localparam int unsigned PATH_DIR_DIAG    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_t;

    // A vector starts a path when it sits on the border the path enters from.
    function automatic logic path_start(input int unsigned dir,
                                        input logic        col_zero,
                                        input logic        row_zero);
        case (dir)
            PATH_DIR_HORIZ: return col_zero;
            PATH_DIR_VERT:  return row_zero;
            default:        return col_zero | row_zero;
        endcase
    endfunction

endpackage

// File: rtl/sgm_path_sequencer_scan_counter.sv
// sgm_scan_counter: raster column/row counters with enable, wrap and last-pixel flag.
module sgm_scan_counter
    import sgm_path_sequencer_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic                          in_en,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic                          out_last
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

    logic col_last;
    logic row_last;

    assign col_last = (out_col == COL_MAX);
    assign row_last = (out_row == ROW_MAX);
    assign out_last = col_last & row_last;

    // Advance one position per enabled cycle, wrapping at row and frame end.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_col <= '0;
            out_row <= '0;
        end else if (in_en) begin
            if (col_last) begin
                out_col <= '0;
                out_row <= row_last ? '0 : out_row + 1'b1;
            end else begin
                out_col <= out_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sgm_path_sequencer.sv
// sgm_path_sequencer: sequences one SGM path-cost pipeline over a raster frame.
// Optional macro SGM_SEQ_ERR_CHECK_EN enables the sticky protocol-error flag.
module sgm_path_sequencer
    import sgm_path_sequencer_pkg::*;
#(
    parameter int unsigned IMG_WIDTH    = 640,
    parameter int unsigned IMG_HEIGHT   = 480,
    parameter int unsigned PATH_DIR     = 0,
    parameter int unsigned PIPE_LATENCY = 1,
    parameter int unsigned PEN_BITS     = 8,
    parameter int unsigned DEFAULT_P1   = 4,
    parameter int unsigned DEFAULT_P2   = 32
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic                          in_valid,
    output logic                          out_ready,
    input  logic                          in_cfg_wr,
    input  logic [PEN_BITS-1:0]           in_cfg_P1,
    input  logic [PEN_BITS-1:0]           in_cfg_P2,
    output logic [PEN_BITS-1:0]           out_P1,
    output logic [PEN_BITS-1:0]           out_P2,
    output logic                          out_ce,
    output logic                          out_border,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic                          out_L_valid,
    output logic                          out_frame_done,
    output logic                          out_err
);

    localparam int unsigned FC_BITS = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam logic [FC_BITS-1:0] FC_LAST = FC_BITS'(PIPE_LATENCY - 1);

    seq_state_t               state;
    seq_state_t               state_nxt;
    logic                     accept;
    logic                     last_pix;
    logic [FC_BITS-1:0]       flush_cnt;
    logic                     flush_last;
    logic [PIPE_LATENCY-1:0]  lv_sr;
    logic [PEN_BITS-1:0]      pend_p1;
    logic [PEN_BITS-1:0]      pend_p2;
    logic                     pend_valid;
    logic                     apply_pen;

    assign out_ready  = (state != ST_FLUSH);
    assign accept     = in_valid & out_ready;
    assign out_ce     = accept;
    assign flush_last = (flush_cnt == FC_LAST);

    sgm_scan_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_scan (
        .in_clk   (in_clk),
        .in_rst   (in_rst),
        .in_en    (accept),
        .out_col  (out_col),
        .out_row  (out_row),
        .out_last (last_pix)
    );

    assign out_border = path_start(PATH_DIR, out_col == '0, out_row == '0);

    // State register.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and frame-done decode.
    always_comb begin
        state_nxt      = state;
        out_frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && last_pix) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_last) begin
                    state_nxt      = ST_IDLE;
                    out_frame_done = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Count drain cycles while flushing; idle at zero otherwise.
    always_ff @(posedge in_clk) begin
        if (in_rst || state != ST_FLUSH || flush_last) begin
            flush_cnt <= '0;
        end else begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Delay accept by PIPE_LATENCY cycles to mark valid L vectors.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            lv_sr <= '0;
        end else begin
            lv_sr[0] <= accept;
            for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
                lv_sr[i] <= lv_sr[i-1];
            end
        end
    end

    assign out_L_valid = lv_sr[PIPE_LATENCY-1];

    // Penalties only move from pending to active on an IDLE cycle with no accept,
    // so a frame always sees one consistent P1/P2 pair.
    assign apply_pen = (state == ST_IDLE) && !accept && pend_valid;

    // Pending/active penalty double buffer.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_P1     <= PEN_BITS'(DEFAULT_P1);
            out_P2     <= PEN_BITS'(DEFAULT_P2);
            pend_p1    <= '0;
            pend_p2    <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (apply_pen) begin
                out_P1     <= pend_p1;
                out_P2     <= pend_p2;
                pend_valid <= 1'b0;
            end
            // A write in the same cycle as an apply re-arms pending with the new pair.
            if (in_cfg_wr) begin
                pend_p1    <= in_cfg_P1;
                pend_p2    <= in_cfg_P2;
                pend_valid <= 1'b1;
            end
        end
    end

`ifdef SGM_SEQ_ERR_CHECK_EN
    logic err_q;

    // Sticky flag for valid data offered while the sequencer is draining.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            err_q <= 1'b0;
        end else if (in_valid && !out_ready) begin
            err_q <= 1'b1;
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_sgm_path_sequencer.sv
// Scoreboard bench for sgm_path_sequencer (8x4 frame), four parameter variants.
module tb_sgm_path_sequencer;

    localparam int W = 8;
    localparam int H = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vld, vld3, cfg_wr;
    logic [7:0] cfg_p1, cfg_p2;

    logic       rdy  [4];
    logic       ce   [4];
    logic       brd  [4];
    logic       lv   [4];
    logic       done [4];
    logic       err  [4];
    logic [7:0] p1   [4];
    logic [7:0] p2   [4];
    logic [2:0] col  [4];
    logic [1:0] row  [4];

    sgm_path_sequencer #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .PATH_DIR(0), .PIPE_LATENCY(1)) dut0 (
        .in_clk(clk), .in_rst(rst), .in_valid(vld), .out_ready(rdy[0]),
        .in_cfg_wr(cfg_wr), .in_cfg_P1(cfg_p1), .in_cfg_P2(cfg_p2),
        .out_P1(p1[0]), .out_P2(p2[0]), .out_ce(ce[0]), .out_border(brd[0]),
        .out_col(col[0]), .out_row(row[0]), .out_L_valid(lv[0]),
        .out_frame_done(done[0]), .out_err(err[0]));

    sgm_path_sequencer #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .PATH_DIR(1), .PIPE_LATENCY(1)) dut1 (
        .in_clk(clk), .in_rst(rst), .in_valid(vld), .out_ready(rdy[1]),
        .in_cfg_wr(cfg_wr), .in_cfg_P1(cfg_p1), .in_cfg_P2(cfg_p2),
        .out_P1(p1[1]), .out_P2(p2[1]), .out_ce(ce[1]), .out_border(brd[1]),
        .out_col(col[1]), .out_row(row[1]), .out_L_valid(lv[1]),
        .out_frame_done(done[1]), .out_err(err[1]));

    sgm_path_sequencer #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .PATH_DIR(2), .PIPE_LATENCY(1)) dut2 (
        .in_clk(clk), .in_rst(rst), .in_valid(vld), .out_ready(rdy[2]),
        .in_cfg_wr(cfg_wr), .in_cfg_P1(cfg_p1), .in_cfg_P2(cfg_p2),
        .out_P1(p1[2]), .out_P2(p2[2]), .out_ce(ce[2]), .out_border(brd[2]),
        .out_col(col[2]), .out_row(row[2]), .out_L_valid(lv[2]),
        .out_frame_done(done[2]), .out_err(err[2]));

    sgm_path_sequencer #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .PATH_DIR(0), .PIPE_LATENCY(3)) dut3 (
        .in_clk(clk), .in_rst(rst), .in_valid(vld3), .out_ready(rdy[3]),
        .in_cfg_wr(cfg_wr), .in_cfg_P1(cfg_p1), .in_cfg_P2(cfg_p2),
        .out_P1(p1[3]), .out_P2(p2[3]), .out_ce(ce[3]), .out_border(brd[3]),
        .out_col(col[3]), .out_row(row[3]), .out_L_valid(lv[3]),
        .out_frame_done(done[3]), .out_err(err[3]));

    typedef struct {
        int c;
        int r;
        int b0;
        int b1;
        int b2;
        int ep1;
        int ep2;
    } ce_t;

    ce_t ce_q[$];
    int  lq[$];
    int  dq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mcol = 0, mrow = 0, ep1 = 4, ep2 = 32;
    int bcnt [3];
    int l3 = 0, d3 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle; on an expected accept push the response into the scoreboard.
    task automatic step(input bit v, input bit r, input bit cw, input bit h3);
        ce_t e;
        @(posedge clk);
        #1;
        vld    = v;
        vld3   = v | h3;
        rst    = r;
        cfg_wr = cw;
        if (r) begin
            mcol = 0;
            mrow = 0;
        end else if (v) begin
            e.c   = mcol;
            e.r   = mrow;
            e.b0  = (mcol == 0) ? 1 : 0;
            e.b1  = (mrow == 0) ? 1 : 0;
            e.b2  = (mcol == 0 || mrow == 0) ? 1 : 0;
            e.ep1 = ep1;
            e.ep2 = ep2;
            ce_q.push_back(e);
            lq.push_back(cyc + 1);
            if (mcol == W - 1 && mrow == H - 1) begin
                dq.push_back(cyc + 1);
                mcol = 0;
                mrow = 0;
            end else if (mcol == W - 1) begin
                mcol = 0;
                mrow++;
            end else begin
                mcol++;
            end
        end
    endtask

    task automatic bubble_chk();
        @(negedge clk);
        chk("bubble_ce", ce[0], 0);
        chk("bubble_col", col[0], mcol);
        chk("bubble_row", row[0], mrow);
    endtask

    // Monitor: pop and compare whenever the DUT presents an output event.
    always @(negedge clk) begin
        ce_t e;
        int  t;
        if (ce[0]) begin
            if (ce_q.size() == 0) begin
                chk("unexpected_ce", 1, 0);
            end else begin
                e = ce_q.pop_front();
                chk("ce_col", col[0], e.c);
                chk("ce_row", row[0], e.r);
                chk("border_dir0", brd[0], e.b0);
                chk("border_dir1", brd[1], e.b1);
                chk("border_dir2", brd[2], e.b2);
                chk("ce_P1", p1[0], e.ep1);
                chk("ce_P2", p2[0], e.ep2);
            end
        end
        if (lv[0]) begin
            if (lq.size() == 0) begin
                chk("unexpected_L_valid", 1, 0);
            end else begin
                t = lq.pop_front();
                chk("L_valid_cycle", cyc, t);
            end
        end
        if (done[0]) begin
            if (dq.size() == 0) begin
                chk("unexpected_frame_done", 1, 0);
            end else begin
                t = dq.pop_front();
                chk("frame_done_cycle", cyc, t);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (ce[k] && brd[k]) bcnt[k]++;
        end
        if (lv[3]) l3++;
        if (done[3]) d3++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int k;
        int exp_err;
`ifdef SGM_SEQ_ERR_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        vld = 0; vld3 = 0; rst = 1; cfg_wr = 0; cfg_p1 = 0; cfg_p2 = 0;
        bcnt[0] = 0; bcnt[1] = 0; bcnt[2] = 0;

        // Reset
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("rst_ready", rdy[0], 1);
        chk("rst_L_valid", lv[0], 0);
        chk("rst_frame_done", done[0], 0);
        chk("rst_err", err[0], 0);
        chk("rst_col", col[0], 0);
        chk("rst_row", row[0], 0);
        chk("rst_P1", p1[0], 4);
        chk("rst_P2", p2[0], 32);

        // Frame A: back-to-back
        bcnt[0] = 0; bcnt[1] = 0; bcnt[2] = 0;
        repeat (32) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("flush_ready", rdy[0], 0);
        chk("flush_ready_lat3", rdy[3], 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("ready_after_flush", rdy[0], 1);
        repeat (3) step(0, 0, 0, 0);
        @(negedge clk);
        chk("border_count_dir0", bcnt[0], 4);
        chk("border_count_dir1", bcnt[1], 8);
        chk("border_count_dir2", bcnt[2], 11);

        // Frame B: bubble every 3rd cycle, penalty write mid-frame
        cfg_p1 = 8'd10; cfg_p2 = 8'd50;
        n = 0; k = 0;
        while (n < 32) begin
            if (k % 3 == 2) begin
                step(0, 0, 0, 0);
                bubble_chk();
            end else begin
                step(1, 0, (n == 10), 0);
                n++;
            end
            k++;
        end
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("flush_P1_held", p1[0], 4);
        repeat (4) step(0, 0, 0, 0);
        @(negedge clk);
        chk("idle_P1_applied", p1[0], 10);
        chk("idle_P2_applied", p2[0], 50);
        ep1 = 10; ep2 = 50;

        // Frame C: penalty write on the first accept is deferred a frame
        cfg_p1 = 8'd7; cfg_p2 = 8'd60;
        step(1, 0, 1, 0);
        repeat (31) step(1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        @(negedge clk);
        chk("deferred_P1", p1[0], 7);
        chk("deferred_P2", p2[0], 60);
        ep1 = 7; ep2 = 60;

        // Frame D: reset at col=3,row=2
        repeat (19) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("midrst_col", col[0], 0);
        chk("midrst_row", row[0], 0);
        chk("midrst_ready", rdy[0], 1);
        chk("midrst_P1", p1[0], 4);
        chk("midrst_P2", p2[0], 32);
        chk("midrst_L_discard_lat3", lv[3], 0);
        ep1 = 4; ep2 = 32;
        repeat (3) step(0, 0, 0, 0);

        // Frame E: valid held through the 3-cycle drain of the latency-3 variant
        repeat (32) step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            @(negedge clk);
            chk("lat3_flush_ready", rdy[3], 0);
            if (i == 2) chk("lat3_done_with_last_L", int'(done[3] && lv[3]), 1);
        end
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("lat3_ready_back", rdy[3], 1);
        chk("lat3_no_accept_col", col[3], 0);
        chk("lat3_err", err[3], exp_err);
        repeat (3) step(0, 0, 0, 0);
        @(negedge clk);
        chk("lat3_err_sticky", err[3], exp_err);
        chk("lat1_err_clear", err[0], 0);
        chk("lat3_L_count", l3, 145);
        chk("lat3_done_count", d3, 4);
        chk("ce_queue_empty", ce_q.size(), 0);
        chk("L_queue_empty", lq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
